hazard_ctrl: RTL

//  Pipeline sequencer for the 5-stage RV32 core: issues stall/flush to the F/D/E/M pipeline registers and

---
 rtl/hazard_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/forwarding sequencer for the 5-stage RV32 core
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   validD, rs1D, rs2D, rdD  decode-stage instruction fields
//   RegWriteD, MemtoRegD     decode-stage writes-rd / is-load flags
//   PCBranchE                taken branch resolved in execute this cycle
//   mem_busy                 data memory cannot complete the M access
//   stallF/D/E/M, flushD/E   pipeline register controls
//   fwdAE, fwdBE             execute operand selects (00 regfile, 01 W, 10 M)
//   stall_cnt, flush_cnt     saturating event counters
//   hold_err                 sticky memory-hold timeout flag
module hazard_ctrl #(
    parameter int CNT_W        = 32,
    parameter int HOLD_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             validD,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic [4:0]       rdD,
    input  logic             RegWriteD,
    input  logic             MemtoRegD,
    input  logic             PCBranchE,
    input  logic             mem_busy,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic [1:0]       fwdAE,
    output logic [1:0]       fwdBE,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             hold_err
);

    localparam int HW = $clog2(HOLD_TIMEOUT + 1);
    localparam logic [HW-1:0] HOLD_LIMIT = HW'(HOLD_TIMEOUT);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

    // Shadow copy of one pipeline slot; M and W only use v/rd/w.
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       w;
        logic       ld;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } slot_t;

    state_t           state_q, state_d;
    slot_t            e_q, e_d, m_q, m_d, w_q, w_d;
    logic [HW-1:0]    hold_ctr_q, hold_ctr_d;
    logic             hold_err_q, hold_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic hold, br, lu_hit, lu;
    logic stall_fd, flush_e;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input slot_t m, input slot_t w);
        if (m.v && m.w && m.rd != 5'd0 && m.rd == rs)
            return 2'b10;
        else if (w.v && w.w && w.rd != 5'd0 && w.rd == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            e_q         <= '0;
            m_q         <= '0;
            w_q         <= '0;
            hold_ctr_q  <= '0;
            hold_err_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            e_q         <= e_d;
            m_q         <= m_d;
            w_q         <= w_d;
            hold_ctr_q  <= hold_ctr_d;
            hold_err_q  <= hold_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (mem_busy)  state_d = HOLD;
            HOLD:    if (!mem_busy) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Output / datapath logic. The hold takes effect in the very cycle
    // mem_busy is high and releases in the cycle it drops, so the pipeline
    // is frozen exactly for the busy cycles; state_q is the registered view.
    always_comb begin
        hold   = mem_busy;
        br     = !hold && PCBranchE;
        lu_hit = e_q.v && e_q.ld && (e_q.rd != 5'd0) && validD &&
                 ((e_q.rd == rs1D) || (e_q.rd == rs2D));
        lu     = !hold && !br && lu_hit;

        stall_fd = hold || lu;
        flush_e  = br || lu;

        // Scoreboard mirrors the pipeline registers; a flushed/stalled E gets a bubble.
        e_d = e_q;
        m_d = m_q;
        w_d = w_q;
        if (!hold) begin
            w_d = m_q;
            m_d = e_q;
            if (flush_e)
                e_d = '0;
            else
                e_d = '{v: validD, rd: rdD, w: RegWriteD, ld: MemtoRegD, rs1: rs1D, rs2: rs2D};
        end

        hold_ctr_d = '0;
        if (hold)
            hold_ctr_d = (hold_ctr_q == HOLD_LIMIT) ? hold_ctr_q : hold_ctr_q + 1'b1;
        // A busy cycle arriving with HOLD_LIMIT cycles already counted exceeds the limit.
        hold_err_d = hold_err_q || (hold && hold_ctr_q >= HOLD_LIMIT);

        stall_cnt_d = stall_cnt_q;
        if (stall_fd && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 1'b1;
        flush_cnt_d = flush_cnt_q;
        if (br && flush_cnt_q != '1)
            flush_cnt_d = flush_cnt_q + 1'b1;

        // Reset forces the controls quiet even though mem_busy/PCBranchE feed them directly.
        stallF = rst && stall_fd;
        stallD = rst && stall_fd;
        stallE = rst && hold;
        stallM = rst && hold;
        flushD = rst && br;
        flushE = rst && flush_e;

        fwdAE = fwd_sel(e_q.rs1, m_q, w_q);
        fwdBE = fwd_sel(e_q.rs2, m_q, w_q);
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign hold_err  = hold_err_q;

endmodule
